lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store port between the datapath's memory stage and the data memory. Produces the load word that the writeback select forwards to the register file when memtoreg=1.
- Accepts memread/memwrite requests with address, store data and access size, and issues one valid/ready memory transaction per access.
- Aligns and byte-masks store data; extracts and sign- or zero-extends load data.
- Stalls the pipeline until the access completes.

Parameters:
- w, 32, data and address width. Only 32 is supported; any other value is a synthesis-time error.
- TMO, 255, maximum cycles to wait for mem_resp_valid before signalling bus_err (1..255).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- memread  input  1  load request from the memory stage
- memwrite  input  1  store request from the memory stage
- addr  input  w  byte address (ALU result)
- wdata  input  w  store data (rs2)
- size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- load_unsigned  input  1  1 = zero-extend, 0 = sign-extend
- rd  output  w  registered, extended load data for writeback
- stall  output  1  hold the pipeline
- misalign  output  1  combinational misaligned-access flag
- bus_err  output  1  one-cycle pulse on response timeout
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  memory accepts request
- mem_we  output  1  1 = write
- mem_addr  output  w  word-aligned address, {addr[w-1:2],2'b00}
- mem_wdata  output  w  lane-replicated store data
- mem_be  output  w/8  byte enables
- mem_resp_valid  input  1  read data valid
- mem_rdata  input  w  read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rd=0; mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; bus_err=0; timeout counter=0.
  - Any in-flight transaction is abandoned; a late mem_resp_valid after reset is ignored.
- misalign:
  - 1 when (memread|memwrite) and either size=01 with addr[0]=1, or size=10/11 with addr[1:0]!=0.
  - A misaligned access issues no transaction and does not assert stall.
- memread and memwrite both high: write takes priority; memread is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: on an aligned access, latch we, addr[1:0], size, load_unsigned, mem_addr, mem_wdata and mem_be; go to REQ.
  - REQ: mem_req_valid=1 and all request fields held stable until mem_req_ready=1.
    - On the handshake, a write goes to DONE and a read goes to RESP.
    - mem_req_valid must not drop before the handshake.
  - RESP: counter increments each cycle.
    - On mem_resp_valid: rd <= extended data; go to DONE.
    - If the counter reaches TMO first: rd <= 0, bus_err pulses for 1 cycle, go to DONE.
    - mem_resp_valid in the same cycle the counter reaches TMO counts as a valid response (no error).
  - DONE: one cycle, then IDLE. The pipeline advances this cycle, so the next instruction is sampled in IDLE.
- stall = (IDLE and aligned access) or REQ or RESP. It is 0 in DONE.
- Minimum access latency:
  - store: 2 stall cycles (IDLE, REQ), with ready in the first REQ cycle.
  - load: 3 stall cycles (IDLE, REQ, RESP), with response one cycle after the handshake.
- Store lanes:
  - byte: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<addr[1:0]
  - half: mem_wdata={2{wdata[15:0]}}, mem_be=4'b0011<<addr[1:0]
  - word: mem_wdata=wdata, mem_be=4'b1111
- Loads: mem_be=4'b1111, mem_we=0.
- Load extraction: shifted = mem_rdata >> (8*addr[1:0]).
  - byte: bit 7 sign-extended, or zero-extended if load_unsigned.
  - half: bit 15 sign-extended, or zero-extended if load_unsigned.
  - word: shifted, no extension.
- rd holds its value until the next completed load or timeout. Stores do not change rd.
- mem_resp_valid outside RESP is ignored.

Test Plan:
- Reset mid-load: assert rst_n=0 in RESP, then release and pulse mem_resp_valid. Required: state IDLE, rd=0, stall=0, no update of rd.
- Store byte: addr=0x1003, wdata=0x000000A5, size=00, ready=1. Required: mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, stall high for 2 cycles.
- Load half signed: addr=0x2002, mem_rdata=0x8001_1234, size=01, load_unsigned=0. Required: rd=0xFFFF8001. Repeat with load_unsigned=1: rd=0x00008001.
- Backpressure: mem_req_ready low for 5 cycles on a word load. Required: mem_req_valid and request fields stable throughout, stall held, and handshake on the 6th cycle.
- Misaligned word: addr=0x3002, memread=1, size=10. Required: misalign=1, stall=0, mem_req_valid never asserted.
- Timeout: TMO=4, no mem_resp_valid. Required: bus_err pulses on the 4th RESP cycle, rd=0, DONE next cycle, then IDLE. Also check response and timeout in the same cycle: rd loads data and bus_err=0.

Source files
------------

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port
// Description : Load/store port between the memory stage and data memory.
//               Issues one valid/ready transaction per aligned access, lanes
//               and byte-masks store data, extracts and extends load data,
//               and stalls the pipeline until the access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
    parameter int w   = 32,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           memread,
    input  logic           memwrite,
    input  logic [w-1:0]   addr,
    input  logic [w-1:0]   wdata,
    input  logic [1:0]     size,
    input  logic           load_unsigned,
    output logic [w-1:0]   rd,
    output logic           stall,
    output logic           misalign,
    output logic           bus_err,
    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output logic           mem_we,
    output logic [w-1:0]   mem_addr,
    output logic [w-1:0]   mem_wdata,
    output logic [w/8-1:0] mem_be,
    input  logic           mem_resp_valid,
    input  logic [w-1:0]   mem_rdata
);

    // Unsupported parameter values stop elaboration.
    generate
        if (w != 32) begin : g_bad_width
            $error("lsu_mem_port: only w=32 is supported");
        end
        if ((TMO < 1) || (TMO > 255)) begin : g_bad_tmo
            $error("lsu_mem_port: TMO must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] TMO_LIM = 8'(TMO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic           access;
    logic           bad_align;
    logic           start;
    logic [w-1:0]   lane_wdata;
    logic [w/8-1:0] lane_be;
    logic [1:0]     lo_q;
    logic [1:0]     size_q;
    logic           uns_q;
    logic [7:0]     cnt;
    logic [7:0]     cnt_inc;
    logic           timeout;
    logic [w-1:0]   shifted;
    logic [w-1:0]   load_ext;

    // Alignment check on the incoming request; size 11 behaves like a word.
    always_comb begin
        access = memread | memwrite;
        case (size)
            2'b00:   bad_align = 1'b0;
            2'b01:   bad_align = addr[0];
            default: bad_align = (addr[1:0] != 2'b00);
        endcase
        misalign = access & bad_align;
        start    = access & ~bad_align;
    end

    // Store lane replication and byte enables; loads read the whole word.
    always_comb begin
        lane_wdata = '0;
        lane_be    = 4'b1111;
        if (memwrite) begin
            case (size)
                2'b00: begin
                    lane_wdata = {4{wdata[7:0]}};
                    lane_be    = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    lane_wdata = {2{wdata[15:0]}};
                    lane_be    = 4'b0011 << addr[1:0];
                end
                default: begin
                    lane_wdata = wdata;
                    lane_be    = 4'b1111;
                end
            endcase
        end
    end

    // Response timeout: fires on the TMO-th cycle spent waiting in RESP.
    always_comb begin
        cnt_inc = cnt + 8'd1;
        timeout = (cnt_inc == TMO_LIM);
    end

    // Load data extraction from the byte lane selected by the latched offset.
    always_comb begin
        shifted = mem_rdata >> {lo_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = uns_q ? {{(w-8){1'b0}}, shifted[7:0]}
                                      : {{(w-8){shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {{(w-16){1'b0}}, shifted[15:0]}
                                      : {{(w-16){shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, stall, request valid and timeout pulse.
    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        bus_err       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = mem_we ? DONE : RESP;
            end
            RESP: begin
                stall = 1'b1;
                if (mem_resp_valid) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    bus_err   = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request when an aligned access is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            lo_q      <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
        end else if ((state == IDLE) && start) begin
            mem_we    <= memwrite;
            mem_addr  <= {addr[w-1:2], 2'b00};
            mem_wdata <= lane_wdata;
            mem_be    <= lane_be;
            lo_q      <= addr[1:0];
            size_q    <= size;
            uns_q     <= load_unsigned;
        end
    end

    // Cycle counter for the response wait; cleared outside RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= 8'd0;
        else if (state == RESP)  cnt <= cnt_inc;
        else                     cnt <= 8'd0;
    end

    // Writeback load register: updated only by a response or a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else if (state == RESP) begin
            if (mem_resp_valid) rd <= load_ext;
            else if (timeout)   rd <= '0;
        end
    end

endmodule
`default_nettype wire
